// File: rtl/efm_pipe_stage_pkg.sv
// Shared constants for the NC-DDSM segmented pipeline.
// Used by the input skewing stage, the EFM stage and the cascade top.
// All of them must agree on the segment count and on the per-segment skew.
package efm_pipe_stage_pkg;

    // The accumulator is split into four equal segments.
    localparam int SEG_COUNT = 4;

    // Pipeline skew in clock cycles of each segment, relative to the LSB.
    localparam int SKEW_MSB  = 3;
    localparam int SKEW_ISB1 = 2;
    localparam int SKEW_ISB2 = 1;
    localparam int SKEW_LSB  = 0;

    // Full accumulator width for a given segment width.
    function automatic int total_width(input int seg_w);
        return SEG_COUNT * seg_w;
    endfunction

endpackage

// File: rtl/efm_pipe_stage_delay.sv
// Fixed-depth register delay line (DELAY_UNIT). It skews the enable and
// aligns the residue segments.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_d            : input word
//   o_q            : i_d delayed by P_DEPTH clocks (P_DEPTH >= 1)
// Every stage resets to P_RST_VAL, so the output already holds that value
// while the line is still filling after reset.
module efm_delay_unit #(
    parameter int                 P_WIDTH   = 1,
    parameter int                 P_DEPTH   = 1,
    parameter logic [P_WIDTH-1:0] P_RST_VAL = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [P_WIDTH-1:0] i_d,
    output logic [P_WIDTH-1:0] o_q
);

    logic [P_WIDTH-1:0] stage_q [P_DEPTH];

    // Shift register: stage 0 captures the input, and each later stage takes the one before it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                stage_q[i] <= P_RST_VAL;
            end
        end else begin
            stage_q[0] <= i_d;
            for (int i = 1; i < P_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign o_q = stage_q[P_DEPTH-1];

endmodule

// File: rtl/efm_pipe_stage_seg_acc.sv
// One segment of the pipelined error-feedback accumulator.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : segment enable (already skewed for this segment)
//   i_in           : input segment
//   i_carry        : registered carry from the next-lower segment
//   o_acc          : registered accumulator segment
//   o_carry        : registered carry-out, cleared in any cycle that is not enabled
// When the segment is disabled it forces its carry-out to 0. A carry is
// therefore consumed by the next segment exactly once.
module efm_seg_acc #(
    parameter int                       P_INPUT_WIDTH = 6,
    parameter logic [P_INPUT_WIDTH-1:0] P_RST_VAL     = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [P_INPUT_WIDTH-1:0] i_in,
    input  logic                     i_carry,
    output logic [P_INPUT_WIDTH-1:0] o_acc,
    output logic                     o_carry
);

    logic [P_INPUT_WIDTH:0]   sum_s;
    logic [P_INPUT_WIDTH-1:0] acc_q;
    logic [P_INPUT_WIDTH-1:0] acc_d;
    logic                     carry_q;
    logic                     carry_d;

    // Next-state logic: add with carry when enabled, otherwise hold and drop the carry.
    always_comb begin
        sum_s   = {1'b0, acc_q} + {1'b0, i_in} + {{P_INPUT_WIDTH{1'b0}}, i_carry};
        acc_d   = acc_q;
        carry_d = 1'b0;
        if (i_en) begin
            acc_d   = sum_s[P_INPUT_WIDTH-1:0];
            carry_d = sum_s[P_INPUT_WIDTH];
        end else begin
            acc_d   = acc_q;
            carry_d = 1'b0;
        end
    end

    // State registers for the accumulator segment and its carry-out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= P_RST_VAL;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign o_acc   = acc_q;
    assign o_carry = carry_q;

endmodule

// File: rtl/efm_pipe_stage.sv
// Pipelined first-order error-feedback accumulator stage of the NC-DDSM.
// Inputs arrive with the segments skewed 3/2/1/0 cycles (msb/isb1/isb2/lsb).
// The carry ripples up by one segment per clock.
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_en                     : sample enable, timed with i_lsb
//   i_msb/i_isb1/i_isb2/i_lsb: skewed input segments
//   o_carry                  : MSB overflow (modulator bit). For a sample whose LSB
//                              enters at edge k, it is valid after edge k+4.
//   o_msb/o_isb1/o_isb2/o_lsb: skewed residue, fed to the next cascaded stage
//   o_acc                    : de-skewed residue, aligned with o_carry (debug)
module efm_pipe_stage
    import efm_pipe_stage_pkg::*;
#(
    parameter int                       P_INPUT_WIDTH = 6,
    parameter logic [P_INPUT_WIDTH-1:0] P_LSB_SEED    = '0
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_en,
    input  logic [P_INPUT_WIDTH-1:0]           i_msb,
    input  logic [P_INPUT_WIDTH-1:0]           i_isb1,
    input  logic [P_INPUT_WIDTH-1:0]           i_isb2,
    input  logic [P_INPUT_WIDTH-1:0]           i_lsb,
    output logic                               o_carry,
    output logic [P_INPUT_WIDTH-1:0]           o_msb,
    output logic [P_INPUT_WIDTH-1:0]           o_isb1,
    output logic [P_INPUT_WIDTH-1:0]           o_isb2,
    output logic [P_INPUT_WIDTH-1:0]           o_lsb,
    output logic [SEG_COUNT*P_INPUT_WIDTH-1:0] o_acc
);

    localparam int LP_TOTAL_W = total_width(P_INPUT_WIDTH);

    logic                     en_isb2_s, en_isb1_s, en_msb_s;
    logic                     c_lsb_s, c_isb2_s, c_isb1_s, c_msb_s;
    logic [P_INPUT_WIDTH-1:0] acc_lsb_s, acc_isb2_s, acc_isb1_s, acc_msb_s;
    logic [P_INPUT_WIDTH-1:0] acc_lsb_dly_s, acc_isb2_dly_s, acc_isb1_dly_s;
    logic                     carry_q, carry_d;
    logic [LP_TOTAL_W-1:0]    acc_q, acc_d;

    // The enable follows the data up the segment skew.
    efm_delay_unit #(.P_WIDTH(1), .P_DEPTH(SKEW_ISB2), .P_RST_VAL(1'b0)) u_en_isb2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_en), .o_q(en_isb2_s));
    efm_delay_unit #(.P_WIDTH(1), .P_DEPTH(SKEW_ISB1), .P_RST_VAL(1'b0)) u_en_isb1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_en), .o_q(en_isb1_s));
    efm_delay_unit #(.P_WIDTH(1), .P_DEPTH(SKEW_MSB), .P_RST_VAL(1'b0)) u_en_msb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_en), .o_q(en_msb_s));

    efm_seg_acc #(.P_INPUT_WIDTH(P_INPUT_WIDTH), .P_RST_VAL(P_LSB_SEED)) u_lsb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_in(i_lsb),
        .i_carry(1'b0), .o_acc(acc_lsb_s), .o_carry(c_lsb_s));
    efm_seg_acc #(.P_INPUT_WIDTH(P_INPUT_WIDTH), .P_RST_VAL('0)) u_isb2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(en_isb2_s), .i_in(i_isb2),
        .i_carry(c_lsb_s), .o_acc(acc_isb2_s), .o_carry(c_isb2_s));
    efm_seg_acc #(.P_INPUT_WIDTH(P_INPUT_WIDTH), .P_RST_VAL('0)) u_isb1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(en_isb1_s), .i_in(i_isb1),
        .i_carry(c_isb2_s), .o_acc(acc_isb1_s), .o_carry(c_isb1_s));
    efm_seg_acc #(.P_INPUT_WIDTH(P_INPUT_WIDTH), .P_RST_VAL('0)) u_msb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(en_msb_s), .i_in(i_msb),
        .i_carry(c_isb1_s), .o_acc(acc_msb_s), .o_carry(c_msb_s));

    // Lower segments are held back until the MSB of the same sample has been accumulated.
    efm_delay_unit #(.P_WIDTH(P_INPUT_WIDTH), .P_DEPTH(SKEW_MSB - SKEW_LSB), .P_RST_VAL(P_LSB_SEED)) u_al_lsb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(acc_lsb_s), .o_q(acc_lsb_dly_s));
    efm_delay_unit #(.P_WIDTH(P_INPUT_WIDTH), .P_DEPTH(SKEW_MSB - SKEW_ISB2), .P_RST_VAL('0)) u_al_isb2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(acc_isb2_s), .o_q(acc_isb2_dly_s));
    efm_delay_unit #(.P_WIDTH(P_INPUT_WIDTH), .P_DEPTH(SKEW_MSB - SKEW_ISB1), .P_RST_VAL('0)) u_al_isb1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(acc_isb1_s), .o_q(acc_isb1_dly_s));

    // Output next-state: the MSB carry and the aligned residue of the same sample.
    always_comb begin
        carry_d = c_msb_s;
        acc_d   = {acc_msb_s, acc_isb1_dly_s, acc_isb2_dly_s, acc_lsb_dly_s};
    end

    // Output registers. The extra stage keeps o_acc in step with o_carry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            carry_q <= 1'b0;
            acc_q   <= {{((SEG_COUNT-1)*P_INPUT_WIDTH){1'b0}}, P_LSB_SEED};
        end else begin
            carry_q <= carry_d;
            acc_q   <= acc_d;
        end
    end

    assign o_carry = carry_q;
    assign o_acc   = acc_q;
    assign o_msb   = acc_msb_s;
    assign o_isb1  = acc_isb1_s;
    assign o_isb2  = acc_isb2_s;
    assign o_lsb   = acc_lsb_s;

endmodule
